// File: rtl/cla_share_sched_pkg.sv
// Shared types and constants for the serial carry-lookahead adder scheduler.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package cla_share_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int ID_W       = 1;
   localparam int SLICE_BITS = 2;

   // Slice-counter width: enough to count WIDTH/SLICE_BITS slices, never below one bit.
   function automatic int cnt_width(input int width);
      int n;
      n = width / SLICE_BITS;
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cla_share_sched_cla.sv
// Two-bit carry-lookahead adder slice: sum bits and carry-out from generate/propagate terms.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module cla (
   input  logic a0,
   input  logic a1,
   input  logic b0,
   input  logic b1,
   input  logic cin,
   output logic s0,
   output logic s1,
   output logic cout
);

   logic g0, p0, g1, p1, c1;

   assign g0   = a0 & b0;
   assign p0   = a0 ^ b0;
   assign g1   = a1 & b1;
   assign p1   = a1 ^ b1;
   // Both carries come straight from g/p terms rather than rippling through bit 0.
   assign c1   = g0 | (p0 & cin);
   assign s0   = p0 ^ cin;
   assign s1   = p1 ^ c1;
   assign cout = g1 | (p1 & g0) | (p1 & p0 & cin);

endmodule

// File: rtl/cla_share_sched.sv
// Round-robin two-port front end that time-shares one 2-bit CLA slice to add WIDTH-bit operands LSB-first.
// Latency: result valid WIDTH/2+1 cycles after accept; minimum initiation interval WIDTH/2+2 cycles.
// Backpressure: one operation in flight; requesters see ready only in IDLE, DONE holds until rsp_ready.
module cla_share_sched
   import cla_share_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req0_cin,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   input  logic             req1_cin,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [WIDTH-1:0] rsp_sum,
   output logic             rsp_cout,
   output logic             rsp_id,
   output logic             busy
);

   localparam int KW = cnt_width(WIDTH);

   state_t                 state_q, state_d;
   logic                   last_grant_q;
   logic [KW-1:0]          k_q;
   logic                   carry_q;
   logic [WIDTH-1:0]       a_q, b_q, sum_q;
   logic [ID_W-1:0]        id_q;

   logic                   grant_id;
   logic                   any_valid;
   logic                   accept;
   logic                   last_slice;
   logic [KW:0]            lsb;
   logic [SLICE_BITS-1:0]  a_sl, b_sl;
   logic                   s0, s1, slice_cout;

   // Round-robin pick: on a tie the requester not served last wins.
   always_comb begin
      grant_id = 1'b0;
      if (req0_valid && req1_valid) begin
         grant_id = ~last_grant_q;
      end else if (req1_valid) begin
         grant_id = 1'b1;
      end
   end

   assign any_valid  = req0_valid | req1_valid;
   assign accept     = (state_q == IDLE) && any_valid;
   assign last_slice = (k_q == KW'(WIDTH / SLICE_BITS - 1));
   assign lsb        = {k_q, 1'b0};
   assign a_sl       = a_q[lsb +: SLICE_BITS];
   assign b_sl       = b_q[lsb +: SLICE_BITS];

   cla u_cla (
      .a0   (a_sl[0]),
      .a1   (a_sl[1]),
      .b0   (b_sl[0]),
      .b1   (b_sl[1]),
      .cin  (carry_q),
      .s0   (s0),
      .s1   (s1),
      .cout (slice_cout)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: accept from IDLE, walk all slices in RUN, wait for the consumer in DONE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_valid)  state_d = RUN;
         RUN:     if (last_slice) state_d = DONE;
         DONE:    if (rsp_ready)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs: ready only for the granted requester while IDLE, response only in DONE.
   always_comb begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      rsp_valid  = 1'b0;
      busy       = (state_q != IDLE);
      case (state_q)
         IDLE: begin
            req0_ready = req0_valid && !grant_id;
            req1_ready = req1_valid &&  grant_id;
         end
         DONE:    rsp_valid = 1'b1;
         default: ;
      endcase
   end

   // Operand capture at accept, then one slice per cycle with the carry held between slices.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q          <= '0;
         b_q          <= '0;
         sum_q        <= '0;
         carry_q      <= 1'b0;
         k_q          <= '0;
         id_q         <= '0;
         last_grant_q <= 1'b1;
      end else if (accept) begin
         a_q          <= grant_id ? req1_a   : req0_a;
         b_q          <= grant_id ? req1_b   : req0_b;
         carry_q      <= grant_id ? req1_cin : req0_cin;
         sum_q        <= '0;
         k_q          <= '0;
         id_q         <= grant_id;
         last_grant_q <= grant_id;
      end else if (state_q == RUN) begin
         sum_q[lsb +: SLICE_BITS] <= {s1, s0};
         carry_q                  <= slice_cout;
         // Counter parks on the last slice instead of wrapping; the next accept clears it.
         if (!last_slice) begin
            k_q <= k_q + 1'b1;
         end
      end
   end

   assign rsp_sum  = sum_q;
   assign rsp_cout = carry_q;
   assign rsp_id   = id_q;

endmodule

// File: tb/tb_cla_share_sched.sv
// Bench for cla_share_sched: directed corner cases plus randomized two-requester traffic.
// Latency: checks response timing against an accept-relative cycle count.
// Backpressure: drives random response stalls and requester gaps.
module tb_cla_share_sched;

   localparam int W    = 16;
   localparam int HALF = W / 2;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         id;
   } res_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [1:0]   dv = '0;
   logic [W-1:0] da [2];
   logic [W-1:0] db [2];
   logic [1:0]   dc = '0;
   logic         rsp_ready = 1'b1;
   logic         req0_ready, req1_ready, rsp_valid, rsp_cout, rsp_id, busy;
   logic [W-1:0] rsp_sum;

   int   total = 0;
   int   bad = 0;

   res_t exp_q[$];
   bit   m_busy;
   int   m_since;
   bit   m_ptr;
   int   cyc = 0;
   int   acc_cyc = 0;
   int   lat = 0;
   logic prev_valid = 1'b0;
   int   n_done = 0;
   int   n_id [2];
   logic [W-1:0] last_sum;
   logic last_cout, last_id;
   logic id_log[$];

   bit   auto_en [2];
   int   left [2];
   int   gap [2];
   int   gap_max = 0;
   int   rdy_pct = -1;

   always #5 clk = ~clk;

   cla_share_sched #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (dv[0]),
      .req0_ready (req0_ready),
      .req0_a     (da[0]),
      .req0_b     (db[0]),
      .req0_cin   (dc[0]),
      .req1_valid (dv[1]),
      .req1_ready (req1_ready),
      .req1_a     (da[1]),
      .req1_b     (db[1]),
      .req1_cin   (dc[1]),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_sum    (rsp_sum),
      .rsp_cout   (rsp_cout),
      .rsp_id     (rsp_id),
      .busy       (busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: check at the falling edge against the model, advance the model, then drive new inputs.
   task automatic step();
      int         g;
      logic       e0, e1, ev;
      logic [1:0] acc;
      logic [W:0] t;
      res_t       r;
      @(negedge clk);
      cyc++;
      g = -1;
      if (!m_busy) begin
         if (dv[0] && dv[1]) g = m_ptr ? 0 : 1;
         else if (dv[0])     g = 0;
         else if (dv[1])     g = 1;
      end
      e0 = (g == 0);
      e1 = (g == 1);
      ev = m_busy && (m_since >= HALF);
      check_eq("req0_ready", req0_ready, e0);
      check_eq("req1_ready", req1_ready, e1);
      check_eq("rsp_valid", rsp_valid, ev);
      check_eq("busy", busy, m_busy);
      if (rsp_valid && !prev_valid) lat = cyc - acc_cyc;
      prev_valid = rsp_valid;
      if (ev && exp_q.size() > 0) begin
         check_eq("rsp_sum", rsp_sum, exp_q[0].sum);
         check_eq("rsp_cout", rsp_cout, exp_q[0].cout);
         check_eq("rsp_id", rsp_id, exp_q[0].id);
         if (rsp_ready) begin
            last_sum  = rsp_sum;
            last_cout = rsp_cout;
            last_id   = rsp_id;
            id_log.push_back(rsp_id);
            n_done++;
            n_id[int'(exp_q[0].id)]++;
            void'(exp_q.pop_front());
            m_busy = 1'b0;
         end
      end
      if (m_busy && m_since < HALF) m_since++;
      acc = {e1, e0};
      if (g >= 0) begin
         t = {1'b0, da[g]} + {1'b0, db[g]} + (W+1)'(dc[g]);
         r.sum  = t[W-1:0];
         r.cout = t[W];
         r.id   = g[0];
         exp_q.push_back(r);
         m_busy  = 1'b1;
         m_since = 0;
         m_ptr   = g[0];
         acc_cyc = cyc;
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         if (acc[i]) begin
            dv[i] = 1'b0;
            if (left[i] > 0) left[i]--;
            gap[i] = $urandom_range(gap_max, 0);
         end
      end
      for (int i = 0; i < 2; i++) begin
         if (auto_en[i] && !dv[i] && left[i] > 0) begin
            if (gap[i] == 0) begin
               dv[i] = 1'b1;
               da[i] = ($urandom_range(3, 0) == 0) ? '1 : W'($urandom);
               db[i] = W'($urandom);
               dc[i] = 1'($urandom);
            end else begin
               gap[i]--;
            end
         end
      end
      if (rdy_pct >= 0) rsp_ready = ($urandom_range(99, 0) < rdy_pct);
   endtask

   task automatic run_until(input int target, input int budget, input string tag);
      int n;
      n = 0;
      while (n_done < target && n < budget) begin
         step();
         n++;
      end
      check_eq(tag, n_done, target);
   endtask

   task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      dv[i] = 1'b1;
      da[i] = a;
      db[i] = b;
      dc[i] = c;
   endtask

   task automatic reset_dut();
      rst_n      = 1'b0;
      m_busy     = 1'b0;
      m_since    = 0;
      m_ptr      = 1'b1;
      prev_valid = 1'b0;
      exp_q.delete();
      #1;
      check_eq("rst_rsp_valid", rsp_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_rsp_sum", rsp_sum, 0);
      check_eq("rst_rsp_cout", rsp_cout, 0);
      check_eq("rst_rsp_id", rsp_id, 0);
      check_eq("rst_req0_ready", req0_ready, dv[0]);
      check_eq("rst_req1_ready", req1_ready, dv[1] & ~dv[0]);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      int n, tgt, b0, b1;
      da[0] = '0; da[1] = '0; db[0] = '0; db[1] = '0;
      auto_en[0] = 1'b0; auto_en[1] = 1'b0;
      left[0] = 0; left[1] = 0; gap[0] = 0; gap[1] = 0;
      n_id[0] = 0; n_id[1] = 0;
      rsp_ready = 1'b1;

      reset_dut();

      // Basic add with latency measurement.
      issue(0, 16'h1234, 16'h4321, 1'b0);
      run_until(1, 40, "t1_done");
      check_eq("t1_sum", last_sum, 16'h5555);
      check_eq("t1_cout", last_cout, 0);
      check_eq("t1_id", last_id, 0);
      check_eq("t1_latency", lat, HALF + 1);

      // Carry rippling through every slice.
      issue(1, 16'hFFFF, 16'h0001, 1'b0);
      run_until(2, 40, "t2_done");
      check_eq("t2_sum", last_sum, 16'h0000);
      check_eq("t2_cout", last_cout, 1);
      check_eq("t2_id", last_id, 1);
      issue(1, 16'hFFFF, 16'hFFFF, 1'b1);
      run_until(3, 40, "t3_done");
      check_eq("t3_sum", last_sum, 16'hFFFF);
      check_eq("t3_cout", last_cout, 1);

      // Consumer stall in DONE with the other requester waiting.
      rsp_ready = 1'b0;
      issue(0, 16'hA5A5, 16'h5A5A, 1'b1);
      issue(1, 16'h0F0F, 16'h0101, 1'b0);
      n = 0;
      while (!(m_busy && m_since >= HALF) && n < 30) begin
         step();
         n++;
      end
      check_eq("t4_reached_done", rsp_valid, 1);
      repeat (5) step();
      rsp_ready = 1'b1;
      run_until(4, 20, "t4_done");
      check_eq("t4_sum", last_sum, 16'h0000);
      check_eq("t4_cout", last_cout, 1);
      check_eq("t4_id", last_id, 0);
      run_until(5, 40, "t4b_done");
      check_eq("t4b_sum", last_sum, 16'h1010);
      check_eq("t4b_id", last_id, 1);

      // Reset in the middle of an operation.
      issue(0, 16'hFFFF, 16'h0000, 1'b1);
      n = 0;
      while (!(m_busy && m_since >= 3) && n < 30) begin
         step();
         n++;
      end
      dv = '0;
      #2;
      reset_dut();
      repeat (12) step();
      tgt = n_done + 1;
      issue(0, 16'h00FF, 16'h0001, 1'b0);
      run_until(tgt, 40, "t5_done");
      check_eq("t5_sum", last_sum, 16'h0100);
      check_eq("t5_cout", last_cout, 0);

      // Both requesters held valid from reset: grants must alternate starting with 0.
      issue(0, 16'h1111, 16'h2222, 1'b0);
      issue(1, 16'h3333, 16'h4444, 1'b1);
      auto_en[0] = 1'b1; auto_en[1] = 1'b1;
      left[0] = 2; left[1] = 2;
      gap_max = 0;
      reset_dut();
      id_log.delete();
      tgt = n_done + 4;
      run_until(tgt, 80, "t6_done");
      for (int k = 0; k < 4; k++) begin
         check_eq("t6_grant_order", (k < id_log.size()) ? 32'(id_log[k]) : 32'hDEAD, k % 2);
      end

      // Random traffic with requester gaps and consumer stalls.
      b0 = n_id[0];
      b1 = n_id[1];
      left[0] = 500; left[1] = 500;
      gap_max = 3;
      rdy_pct = 70;
      tgt = n_done + 1000;
      run_until(tgt, 40000, "rand_done");
      check_eq("rand_req0_served", n_id[0] - b0, 500);
      check_eq("rand_req1_served", n_id[1] - b1, 500);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cla_share_sched.md
# cla_share_sched

Sequencer and two-port arbiter that time-shares a single 2-bit carry-lookahead slice (`cla`) to perform WIDTH-bit additions serially, two bits per clock. Two requesters submit operand pairs over valid/ready handshakes; a round-robin grant selects one, the block steps it through the slice LSB-first with a registered inter-slice carry, and it returns the sum on a response handshake. It sits between operand producers (multiplier partial-product stages) and the shared adder slice.

## Interface

- WIDTH, 16, operand/sum width; even, ≥ 2.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  requester 0 transfer accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_cin  in  1  requester 0 carry-in.
- req1_valid, req1_ready, req1_a, req1_b, req1_cin: same as requester 0.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_sum  out  WIDTH  sum.
- rsp_cout  out  1  carry-out of the MSB slice.
- rsp_id  out  1  requester index of this result.
- busy  out  1  state ≠ IDLE.

## Operation

- States: IDLE, RUN, DONE.
- IDLE: if any reqN_valid, grant. Both valid → grant the requester not granted last; one valid → grant it. reqN_ready asserted combinationally for the granted requester only, and only in IDLE. On valid&ready: latch a, b, cin, id; clear slice counter k; carry register ← cin; → RUN.
- RUN: each cycle drive slice with a[2k+1:2k], b[2k+1:2k], carry register; write s1,s0 into sum[2k+1:2k]; carry register ← cout; k ← k+1. On k = WIDTH/2−1, after that write → DONE.
- DONE: rsp_valid=1; rsp_sum, rsp_cout (final carry register), rsp_id held stable. On rsp_ready → IDLE; last-grant pointer already updated at accept.
- No acceptance in RUN or DONE; both reqN_ready = 0.
- Requesters hold valid and data until ready; block samples only at the handshake.
- Arithmetic: {rsp_cout, rsp_sum} = a + b + cin, WIDTH+1 bits, unsigned, no truncation beyond cout.
- Counter width max(1, $clog2(WIDTH/2)); no wrap inside an operation.

## Timing

- Reset (async assert, synchronous-release use): state IDLE, k=0, carry=0, sum=0, rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0, busy=0, reqN_ready=0 unless IDLE with valid. Last-grant pointer = 1 (req0 wins first tie).
- Accept edge T; RUN edges T+1..T+WIDTH/2; rsp_valid high from cycle after edge T+WIDTH/2, i.e. WIDTH/2+1 cycles after accept (9 for WIDTH=16).
- rsp_ready already high in DONE: response completes in one cycle; next accept earliest one cycle after DONE exit. Minimum initiation interval WIDTH/2+2 cycles.
- rsp_ready low: DONE held indefinitely, outputs stable.
- rst_n low mid-RUN or mid-DONE: operation discarded, no response emitted, outputs return to reset values immediately.
- Valid withdrawn by requester in IDLE before handshake: no grant, pointer unchanged.

## Structure

- Package cla_share_pkg: state enum (IDLE, RUN, DONE), requester-id width constant (1), SLICE_BITS = 2.
- One sub-module: a single instance of the existing 2-bit slice `cla` (a0,a1,b0,b1,cin → s0,s1,cout); no other adder logic in this block.
- Arbiter, FSM, counter, operand/sum registers inline.

## Test plan

- req0 a=0x1234 b=0x4321 cin=0 → rsp_valid 9 cycles after accept, sum=0x5555, cout=0, id=0.
- req1 a=0xFFFF b=0x0001 cin=0 → sum=0x0000, cout=1, id=1 (carry through all 8 slices); a=0xFFFF b=0xFFFF cin=1 → sum=0xFFFF, cout=1.
- Both valid from reset, held continuously → grants 0,1,0,1; each result id matches; no requester starved.
- rsp_ready low 5 cycles in DONE → rsp_valid/sum/cout/id stable, req0_ready=req1_ready=0 throughout; completes on rsp_ready.
- rst_n pulsed low at k=3 of an operation → all outputs reset immediately, no rsp_valid after release; next request 0x00FF+0x0001 → 0x0100, cout=0.
- Random 1000 operations, random valid/ready stalls → every result equals a+b+cin, responses in accept order.
